// File: rtl/hms_clock_counter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : hms_clock_counter                                          |
// | Description : BCD hours/minutes/seconds clock with manual set/clear and  |
// |               registered seven-segment drive for six HEX digits.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hms_clock_counter #(
  parameter bit MODE12      = 1'b0,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       clk50m,
  input  logic       rstn,
  input  logic       i_tick,
  input  logic       i_run,
  input  logic       i_set_m,
  input  logic       i_set_h,
  input  logic       i_clr,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic [7:0] o_hour,
  output logic [6:0] o_hex0,
  output logic [6:0] o_hex1,
  output logic [6:0] o_hex2,
  output logic [6:0] o_hex3,
  output logic [6:0] o_hex4,
  output logic [6:0] o_hex5,
  output logic       o_day
);

  // Cleared time is 00:00:00 in 24-hour mode and 12:00:00 in 12-hour mode
  localparam logic [3:0] c_hour_t_clr = MODE12 ? 4'd1 : 4'd0;
  localparam logic [3:0] c_hour_u_clr = MODE12 ? 4'd2 : 4'd0;
  // Out-of-range digit code, decodes to all segments off
  localparam logic [3:0] c_blank_code = 4'd15;

  // BCD digit registers and their next-state values
  logic [3:0] sec_u_q, sec_t_q, min_u_q, min_t_q, hour_u_q, hour_t_q;
  logic [3:0] sec_u_d, sec_t_d, min_u_d, min_t_d, hour_u_d, hour_t_d;
  logic       day_q, day_d;

  // Edge-detector history; armed_q blocks events on the first edge after reset
  logic set_m_q, set_h_q, clr_q, armed_q;
  logic set_m_ev, set_h_ev, clr_ev, tick_ev;

  // Registered segment patterns
  logic [6:0] hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;

  // Increment helpers
  logic [3:0] min_u_inc, min_t_inc, hour_u_inc, hour_t_inc;
  logic       min_at_max, hour_at_max;

  // Digit to segments {g,f,e,d,c,b,a}, codes 10..15 blank, output polarity applied
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s ^ {7{SEG_ACT_LOW}};
  endfunction

  // Hour tens digit is suppressed in 12-hour mode when it is zero
  function automatic logic [6:0] hour_tens_seg(input logic [3:0] t);
    return (MODE12 && (t == 4'd0)) ? seg_decode(c_blank_code) : seg_decode(t);
  endfunction

  assign set_m_ev = armed_q & i_set_m & ~set_m_q;
  assign set_h_ev = armed_q & i_set_h & ~set_h_q;
  assign clr_ev   = armed_q & i_clr   & ~clr_q;
  assign tick_ev  = i_tick & i_run;

  // Edge-detect history loads the raw inputs every cycle, including the first after reset
  always_ff @(posedge clk50m or negedge rstn) begin
    if (!rstn) begin
      set_m_q <= 1'b0;
      set_h_q <= 1'b0;
      clr_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      set_m_q <= i_set_m;
      set_h_q <= i_set_h;
      clr_q   <= i_clr;
      armed_q <= 1'b1;
    end
  end

  // Minute and hour successor values, shared by tick carries and manual setting
  always_comb begin
    min_at_max  = (min_t_q == 4'd5) && (min_u_q == 4'd9);
    min_u_inc   = (min_u_q == 4'd9) ? 4'd0 : min_u_q + 4'd1;
    min_t_inc   = min_t_q;
    if (min_at_max) begin
      min_t_inc = 4'd0;
    end else if (min_u_q == 4'd9) begin
      min_t_inc = min_t_q + 4'd1;
    end
    hour_t_inc  = hour_t_q;
    hour_u_inc  = hour_u_q + 4'd1;
    if (MODE12) begin
      hour_at_max = (hour_t_q == 4'd1) && (hour_u_q == 4'd2);
    end else begin
      hour_at_max = (hour_t_q == 4'd2) && (hour_u_q == 4'd3);
    end
    if (hour_at_max) begin
      hour_t_inc = 4'd0;
      hour_u_inc = MODE12 ? 4'd1 : 4'd0;
    end else if (hour_u_q == 4'd9) begin
      hour_t_inc = hour_t_q + 4'd1;
      hour_u_inc = 4'd0;
    end
  end

  // Next time: clear beats set-hour beats set-minute beats tick; losers are dropped
  always_comb begin
    sec_u_d  = sec_u_q;
    sec_t_d  = sec_t_q;
    min_u_d  = min_u_q;
    min_t_d  = min_t_q;
    hour_u_d = hour_u_q;
    hour_t_d = hour_t_q;
    day_d    = 1'b0;
    if (clr_ev) begin
      sec_u_d  = 4'd0;
      sec_t_d  = 4'd0;
      min_u_d  = 4'd0;
      min_t_d  = 4'd0;
      hour_u_d = c_hour_u_clr;
      hour_t_d = c_hour_t_clr;
    end else if (set_h_ev) begin
      hour_u_d = hour_u_inc;
      hour_t_d = hour_t_inc;
    end else if (set_m_ev) begin
      min_u_d = min_u_inc;
      min_t_d = min_t_inc;
    end else if (tick_ev) begin
      if (sec_u_q != 4'd9) begin
        sec_u_d = sec_u_q + 4'd1;
      end else begin
        sec_u_d = 4'd0;
        if (sec_t_q != 4'd5) begin
          sec_t_d = sec_t_q + 4'd1;
        end else begin
          sec_t_d = 4'd0;
          min_u_d = min_u_inc;
          min_t_d = min_t_inc;
          if (min_at_max) begin
            hour_u_d = hour_u_inc;
            hour_t_d = hour_t_inc;
            day_d    = hour_at_max;
          end
        end
      end
    end
  end

  // Time digit registers and the day-rollover pulse
  always_ff @(posedge clk50m or negedge rstn) begin
    if (!rstn) begin
      sec_u_q  <= 4'd0;
      sec_t_q  <= 4'd0;
      min_u_q  <= 4'd0;
      min_t_q  <= 4'd0;
      hour_u_q <= c_hour_u_clr;
      hour_t_q <= c_hour_t_clr;
      day_q    <= 1'b0;
    end else begin
      sec_u_q  <= sec_u_d;
      sec_t_q  <= sec_t_d;
      min_u_q  <= min_u_d;
      min_t_q  <= min_t_d;
      hour_u_q <= hour_u_d;
      hour_t_q <= hour_t_d;
      day_q    <= day_d;
    end
  end

  // Segment patterns follow the digit registers with one cycle of latency
  always_ff @(posedge clk50m or negedge rstn) begin
    if (!rstn) begin
      hex0_q <= seg_decode(4'd0);
      hex1_q <= seg_decode(4'd0);
      hex2_q <= seg_decode(4'd0);
      hex3_q <= seg_decode(4'd0);
      hex4_q <= seg_decode(c_hour_u_clr);
      hex5_q <= hour_tens_seg(c_hour_t_clr);
    end else begin
      hex0_q <= seg_decode(sec_u_q);
      hex1_q <= seg_decode(sec_t_q);
      hex2_q <= seg_decode(min_u_q);
      hex3_q <= seg_decode(min_t_q);
      hex4_q <= seg_decode(hour_u_q);
      hex5_q <= hour_tens_seg(hour_t_q);
    end
  end

  assign o_sec  = {sec_t_q, sec_u_q};
  assign o_min  = {min_t_q, min_u_q};
  assign o_hour = {hour_t_q, hour_u_q};
  assign o_day  = day_q;
  assign o_hex0 = hex0_q;
  assign o_hex1 = hex1_q;
  assign o_hex2 = hex2_q;
  assign o_hex3 = hex3_q;
  assign o_hex4 = hex4_q;
  assign o_hex5 = hex5_q;

endmodule
`default_nettype wire

// File: tb/tb_hms_clock_counter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_hms_clock_counter                                       |
// | Description : Directed self-checking bench for hms_clock_counter, one    |
// |               24-hour and one 12-hour instance on shared stimulus.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hms_clock_counter;

  logic clk50m = 1'b0;
  logic rstn, i_tick, i_run, i_set_m, i_set_h, i_clr;
  logic [7:0] s24, m24, h24, s12, m12, h12;
  logic [6:0] a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5;
  logic d24, d12;
  logic [23:0] t24, t12;
  logic [41:0] hx24;
  int n_chk  = 0;
  int n_fail = 0;

  assign t24  = {h24, m24, s24};
  assign t12  = {h12, m12, s12};
  assign hx24 = {a5, a4, a3, a2, a1, a0};

  always #10 clk50m = ~clk50m;

  hms_clock_counter #(.MODE12(1'b0), .SEG_ACT_LOW(1'b1)) u_dut24 (
    .clk50m(clk50m), .rstn(rstn), .i_tick(i_tick), .i_run(i_run),
    .i_set_m(i_set_m), .i_set_h(i_set_h), .i_clr(i_clr),
    .o_sec(s24), .o_min(m24), .o_hour(h24),
    .o_hex0(a0), .o_hex1(a1), .o_hex2(a2), .o_hex3(a3), .o_hex4(a4), .o_hex5(a5),
    .o_day(d24)
  );

  hms_clock_counter #(.MODE12(1'b1), .SEG_ACT_LOW(1'b1)) u_dut12 (
    .clk50m(clk50m), .rstn(rstn), .i_tick(i_tick), .i_run(i_run),
    .i_set_m(i_set_m), .i_set_h(i_set_h), .i_clr(i_clr),
    .o_sec(s12), .o_min(m12), .o_hour(h12),
    .o_hex0(b0), .o_hex1(b1), .o_hex2(b2), .o_hex3(b3), .o_hex4(b4), .o_hex5(b5),
    .o_day(d12)
  );

  task automatic cyc();
    @(posedge clk50m);
    #1;
  endtask

  task automatic do_tick();
    i_tick = 1'b1; cyc(); i_tick = 1'b0; cyc();
  endtask

  task automatic do_setm();
    i_set_m = 1'b1; cyc(); i_set_m = 1'b0; cyc();
  endtask

  task automatic do_seth();
    i_set_h = 1'b1; cyc(); i_set_h = 1'b0; cyc();
  endtask

  task automatic do_clr();
    i_clr = 1'b1; cyc(); i_clr = 1'b0; cyc();
  endtask

  // From the cleared time, step hours, minutes, then seconds
  task automatic preload(input int h, input int m, input int s);
    i_run = 1'b1;
    do_clr();
    repeat (h) do_seth();
    repeat (m) do_setm();
    repeat (s) do_tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_tick = 1'b0; i_run = 1'b0;
    i_set_m = 1'b1; i_set_h = 1'b1; i_clr = 1'b1;
    #15;
    n_chk++; if (t24 !== 24'h000000) begin n_fail++; $display("FAIL reset_time24: got %h expected 000000", t24); end
    n_chk++; if (d24 !== 1'b0) begin n_fail++; $display("FAIL reset_day24: got %b expected 0", d24); end
    n_chk++; if (hx24 !== {6{7'h40}}) begin n_fail++; $display("FAIL reset_hex24: got %h expected %h", hx24, {6{7'h40}}); end
    n_chk++; if (t12 !== 24'h120000) begin n_fail++; $display("FAIL reset_time12: got %h expected 120000", t12); end
    n_chk++; if ({b5, b4} !== {7'h79, 7'h24}) begin n_fail++; $display("FAIL reset_hex12: got %h %h expected 79 24", b5, b4); end
  endtask

  task automatic test_reset_release();
    cyc();
    rstn = 1'b1;
    repeat (3) cyc();
    n_chk++; if (t24 !== 24'h000000) begin n_fail++; $display("FAIL release_no_event24: got %h expected 000000", t24); end
    n_chk++; if (t12 !== 24'h120000) begin n_fail++; $display("FAIL release_no_event12: got %h expected 120000", t12); end
    i_set_m = 1'b0; i_set_h = 1'b0; i_clr = 1'b0;
    cyc();
    do_setm();
    n_chk++; if (m24 !== 8'h01) begin n_fail++; $display("FAIL release_then_setm: got %h expected 01", m24); end
  endtask

  task automatic test_count();
    i_run = 1'b1;
    do_clr();
    repeat (60) begin
      i_tick = 1'b1; cyc(); i_tick = 1'b0;
      repeat (9) cyc();
    end
    i_tick = 1'b1; cyc(); i_tick = 1'b0;
    n_chk++; if ({m24, s24} !== 16'h0101) begin n_fail++; $display("FAIL count_61: got %h expected 0101", {m24, s24}); end
    n_chk++; if (a0 !== 7'h40) begin n_fail++; $display("FAIL hex_latency: got %h expected 40", a0); end
    cyc();
    n_chk++; if ({a2, a1, a0} !== {7'h79, 7'h40, 7'h79}) begin n_fail++; $display("FAIL hex_count: got %h %h %h expected 79 40 79", a2, a1, a0); end
  endtask

  task automatic test_rollover24();
    preload(23, 0, 0);
    n_chk++; if (h24 !== 8'h23) begin n_fail++; $display("FAIL preload_23: got %h expected 23", h24); end
    i_set_h = 1'b1; cyc(); i_set_h = 1'b0;
    n_chk++; if ({h24, d24} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL seth_wrap24: got %h day %b expected 00 day 0", h24, d24); end
    cyc();
    preload(23, 59, 59);
    n_chk++; if (t24 !== 24'h235959) begin n_fail++; $display("FAIL preload_235959: got %h expected 235959", t24); end
    i_tick = 1'b1; cyc(); i_tick = 1'b0;
    n_chk++; if ({t24, d24} !== {24'h000000, 1'b1}) begin n_fail++; $display("FAIL rollover24: got %h day %b expected 000000 day 1", t24, d24); end
    cyc();
    n_chk++; if (d24 !== 1'b0) begin n_fail++; $display("FAIL day_width24: got %b expected 0", d24); end
    n_chk++; if (hx24 !== {6{7'h40}}) begin n_fail++; $display("FAIL hex_rollover24: got %h expected %h", hx24, {6{7'h40}}); end
  endtask

  task automatic test_rollover12();
    preload(0, 59, 59);
    n_chk++; if (t12 !== 24'h125959) begin n_fail++; $display("FAIL preload_125959: got %h expected 125959", t12); end
    i_tick = 1'b1; cyc(); i_tick = 1'b0;
    n_chk++; if ({t12, d12, d24} !== {24'h010000, 1'b1, 1'b0}) begin n_fail++; $display("FAIL rollover12: got %h day12 %b day24 %b expected 010000 1 0", t12, d12, d24); end
    cyc();
    n_chk++; if (d12 !== 1'b0) begin n_fail++; $display("FAIL day_width12: got %b expected 0", d12); end
    preload(9, 0, 0);
    n_chk++; if ({h12, b5, b4} !== {8'h09, 7'h7F, 7'h10}) begin n_fail++; $display("FAIL blank_tens12: got %h %h %h expected 09 7f 10", h12, b5, b4); end
    do_seth();
    n_chk++; if ({h12, b5, b4} !== {8'h10, 7'h79, 7'h40}) begin n_fail++; $display("FAIL hour_10_12: got %h %h %h expected 10 79 40", h12, b5, b4); end
    do_seth();
    do_seth();
    n_chk++; if (h12 !== 8'h12) begin n_fail++; $display("FAIL hour_12_12: got %h expected 12", h12); end
    i_set_h = 1'b1; cyc(); i_set_h = 1'b0;
    n_chk++; if ({h12, d12} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL seth_wrap12: got %h day %b expected 01 day 0", h12, d12); end
    cyc();
  endtask

  task automatic test_set_m_no_carry();
    preload(10, 59, 30);
    do_setm();
    n_chk++; if (t24 !== 24'h100030) begin n_fail++; $display("FAIL setm_no_carry: got %h expected 100030", t24); end
  endtask

  task automatic test_priority();
    preload(3, 4, 5);
    i_tick = 1'b1; i_set_m = 1'b1; i_clr = 1'b1;
    cyc();
    i_tick = 1'b0; i_set_m = 1'b0; i_clr = 1'b0;
    cyc();
    n_chk++; if (t24 !== 24'h000000) begin n_fail++; $display("FAIL prio_clr: got %h expected 000000", t24); end
    i_tick = 1'b1; i_set_m = 1'b1; i_set_h = 1'b1;
    cyc();
    i_tick = 1'b0; i_set_m = 1'b0; i_set_h = 1'b0;
    cyc();
    n_chk++; if (t24 !== 24'h010000) begin n_fail++; $display("FAIL prio_seth: got %h expected 010000", t24); end
    i_set_m = 1'b1;
    repeat (100) cyc();
    i_set_m = 1'b0;
    cyc();
    n_chk++; if (t24 !== 24'h010100) begin n_fail++; $display("FAIL setm_held: got %h expected 010100", t24); end
  endtask

  task automatic test_run0();
    preload(2, 3, 4);
    i_run = 1'b0;
    repeat (20) do_tick();
    n_chk++; if (t24 !== 24'h020304) begin n_fail++; $display("FAIL run0_hold: got %h expected 020304", t24); end
    do_setm();
    n_chk++; if (t24 !== 24'h020404) begin n_fail++; $display("FAIL run0_setm: got %h expected 020404", t24); end
    do_clr();
    n_chk++; if (t24 !== 24'h000000) begin n_fail++; $display("FAIL run0_clr: got %h expected 000000", t24); end
    i_run = 1'b1;
  endtask

  task automatic test_async_reset();
    preload(5, 43, 21);
    n_chk++; if (t24 !== 24'h054321) begin n_fail++; $display("FAIL preload_054321: got %h expected 054321", t24); end
    #2 rstn = 1'b0;
    #1;
    n_chk++; if ({t24, a0} !== {24'h000000, 7'h40}) begin n_fail++; $display("FAIL async_reset: got %h hex0 %h expected 000000 40", t24, a0); end
    #2 rstn = 1'b1;
    cyc();
    preload(23, 59, 59);
    i_tick = 1'b1; cyc(); i_tick = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_chk++; if (d24 !== 1'b0) begin n_fail++; $display("FAIL async_reset_day: got %b expected 0", d24); end
    #2 rstn = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_count();
    test_rollover24();
    test_rollover12();
    test_set_m_no_carry();
    test_priority();
    test_run0();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
